// File: rtl/fc_pkg.sv
// Purpose : shared defaults, state encoding and helpers for the FC flatten buffer.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents: element/lane/frame defaults, the row-count derivation, the
// fill/run/gap state encoding and the FC controller's idle row address.
package fc_pkg;

   localparam int FC_DATAWIDTH   = 16;
   localparam int FC_LANES       = 16;
   localparam int FC_INPUT_NODES = 784;

   // Address the FC controller parks on between layers; it must always read zero.
   localparam logic [6:0] FC_IDLE_ADDR = 7'd99;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } fc_state_e;

   function automatic int fc_rows(input int nodes, input int lanes);
      return nodes / lanes;
   endfunction

endpackage

// File: rtl/fc_row_bank.sv
// Purpose : ROWS x LANES element store; one element written per cycle, one row read.
// Latency : write lands on the next clk edge; read is combinational (zero cycles).
// Backpr. : none; the caller gates wr_en.
//
// Ports:
//   clk      clock (storage has no reset)
//   wr_en    write strobe for one element
//   wr_row   destination row
//   wr_lane  destination lane within the row (decoded to a per-lane enable)
//   wr_data  element value
//   rd_row   row to present, must be < ROWS
//   rd_data  full row, lane l at bits [DATAWIDTH*l +: DATAWIDTH]
module fc_row_bank #(
   parameter int DATAWIDTH = 16,
   parameter int LANES     = 16,
   parameter int ROWS      = 49,
   localparam int AW       = (ROWS  > 1) ? $clog2(ROWS)  : 1,
   localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_row,
   input  logic [LW-1:0]              wr_lane,
   input  logic [DATAWIDTH-1:0]       wr_data,
   input  logic [AW-1:0]              rd_row,
   output logic [DATAWIDTH*LANES-1:0] rd_data
);

   logic [LANES-1:0][DATAWIDTH-1:0] mem_q [ROWS];
   logic [LANES-1:0]                lane_en;

   always_comb begin
      lane_en = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_en[l] = wr_en && (wr_lane == LW'(l));
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (lane_en[l]) begin
            mem_q[wr_row][l] <= wr_data;
         end
      end
   end

   assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/fc_flatten_buffer.sv
// Purpose : packs the pooled feature stream into LANES-wide rows and serves them to the FC.
// Latency : row read is combinational; RUN (fc_start) rises the cycle after the last element.
// Backpr. : in_ready low while the frame buffer is occupied; elements move on in_valid && in_ready.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready   element stream from the pooling stage
//   fc_weight_addr      row address from the FC controller (rows mirrored at +ROWS)
//   fc_data             addressed row, zero when fc_start is low or address out of range
//   fc_start/fc_done    per-frame level start / completion pulse with the FC controller
//   frame_err           one-cycle pulse: in_last disagreed with the element count
//   frame_done          one-cycle pulse: FC finished with a frame
//
// Build option FC_BUF_PINGPONG_EN: two banks, so the next frame fills while the FC runs.
module fc_flatten_buffer
   import fc_pkg::*;
#(
   parameter int DATAWIDTH   = FC_DATAWIDTH,
   parameter int INPUT_NODES = FC_INPUT_NODES,
   parameter int LANES       = FC_LANES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATAWIDTH-1:0]       in_data,
   input  logic                       in_last,
   output logic                       in_ready,
   input  logic [6:0]                 fc_weight_addr,
   output logic [DATAWIDTH*LANES-1:0] fc_data,
   output logic                       fc_start,
   input  logic                       fc_done,
   output logic                       frame_err,
   output logic                       frame_done
);

   localparam int ROWS = fc_rows(INPUT_NODES, LANES);
   localparam int AW   = (ROWS  > 1) ? $clog2(ROWS)  : 1;
   localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int RW   = DATAWIDTH * LANES;
   localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic [6:0]    ROWS_A    = 7'(ROWS);
   localparam logic [6:0]    ROWS2_A   = 7'(2 * ROWS);

`ifdef FC_BUF_PINGPONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   if (INPUT_NODES % LANES != 0) begin : g_chk_div
      $error("fc_flatten_buffer: INPUT_NODES must be a multiple of LANES");
   end
   // The mirrored address window must end below the idle address.
   if (2 * ROWS > int'(FC_IDLE_ADDR)) begin : g_chk_rows
      $error("fc_flatten_buffer: 2*ROWS must not reach the idle address");
   end

   fc_state_e        state_q, state_d;
   logic [AW-1:0]    row_q, row_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic             in_ready_q, in_ready_d;
   logic             fc_start_q, fc_start_d;
   logic             frame_err_q, frame_err_d;
   logic             frame_done_q, frame_done_d;
   logic             accept, at_last, done_evt, frame_complete;
   logic [NB-1:0]    wr_bank_en;
   logic [RW-1:0]    bank_rd [NB];
   logic [RW-1:0]    rd_bank;
   logic [6:0]       rd_idx;
   logic [AW-1:0]    rd_row;
   logic             rd_hit;

   assign accept   = in_valid && in_ready_q;
   assign at_last  = (row_q == LAST_ROW) && (lane_q == LAST_LANE);
   assign done_evt = (state_q == RUN) && fc_done;

   // Element position and framing check. A premature in_last throws the
   // partial frame away; a missing in_last on the final element is flagged
   // but the frame is kept since its length is right.
   always_comb begin
      row_d          = row_q;
      lane_d         = lane_q;
      frame_err_d    = 1'b0;
      frame_done_d   = done_evt;
      frame_complete = 1'b0;
      if (accept) begin
         if (at_last) begin
            frame_complete = 1'b1;
            frame_err_d    = !in_last;
            row_d          = '0;
            lane_d         = '0;
         end else if (in_last) begin
            frame_err_d = 1'b1;
            row_d       = '0;
            lane_d      = '0;
         end else if (lane_q == LAST_LANE) begin
            row_d  = row_q + 1'b1;
            lane_d = '0;
         end else begin
            lane_d = lane_q + 1'b1;
         end
      end
   end

`ifdef FC_BUF_PINGPONG_EN
   logic       wb_q, wb_d, rb_q, rb_d;
   logic [1:0] full_q, full_d;

   // Completion always targets wb and release always targets rb; the two
   // cannot be the same bank in one cycle, so both updates apply.
   always_comb begin
      full_d = full_q;
      wb_d   = wb_q;
      rb_d   = rb_q;
      if (frame_complete) begin
         full_d[wb_q] = 1'b1;
         wb_d         = !wb_q;
      end
      if (done_evt) begin
         full_d[rb_q] = 1'b0;
         rb_d         = !rb_q;
      end
      state_d = state_q;
      case (state_q)
         FILL:    if (full_d[rb_d]) state_d = RUN;
         RUN:     if (fc_done)      state_d = GAP;
         GAP:     state_d = full_d[rb_d] ? RUN : FILL;
         default: state_d = FILL;
      endcase
      in_ready_d = !full_d[wb_d];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_q <= '0;
         wb_q   <= 1'b0;
         rb_q   <= 1'b0;
      end else begin
         full_q <= full_d;
         wb_q   <= wb_d;
         rb_q   <= rb_d;
      end
   end

   assign wr_bank_en = {accept && wb_q, accept && !wb_q};
   assign rd_bank    = bank_rd[rb_q];
`else
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (frame_complete) state_d = RUN;
         RUN:     if (fc_done)        state_d = GAP;
         GAP:     state_d = FILL;
         default: state_d = FILL;
      endcase
      in_ready_d = (state_d == FILL);
   end

   assign wr_bank_en = accept;
   assign rd_bank    = bank_rd[0];
`endif

   assign fc_start_d = (state_d == RUN);

   // Outputs come straight from flops; reset drops fc_start (and with it
   // fc_data) without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= FILL;
         row_q        <= '0;
         lane_q       <= '0;
         in_ready_q   <= 1'b0;
         fc_start_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         lane_q       <= lane_d;
         in_ready_q   <= in_ready_d;
         fc_start_q   <= fc_start_d;
         frame_err_q  <= frame_err_d;
         frame_done_q <= frame_done_d;
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      fc_row_bank #(
         .DATAWIDTH (DATAWIDTH),
         .LANES     (LANES),
         .ROWS      (ROWS)
      ) u_bank (
         .clk     (clk),
         .wr_en   (wr_bank_en[b]),
         .wr_row  (row_q),
         .wr_lane (lane_q),
         .wr_data (in_data),
         .rd_row  (rd_row),
         .rd_data (bank_rd[b])
      );
   end

   // The FC walks addresses 0..2*ROWS-1 with the second half mirroring the
   // first; anything beyond reads as zero. No register here: the address
   // changes every cycle and the FC expects the row in the same cycle.
   always_comb begin
      rd_hit = 1'b1;
      rd_idx = fc_weight_addr;
      if (fc_weight_addr >= ROWS2_A) begin
         rd_hit = 1'b0;
         rd_idx = '0;
      end else if (fc_weight_addr >= ROWS_A) begin
         rd_idx = fc_weight_addr - ROWS_A;
      end
   end

   assign rd_row     = AW'(rd_idx);
   assign fc_data    = (fc_start_q && rd_hit) ? rd_bank : '0;
   assign in_ready   = in_ready_q;
   assign fc_start   = fc_start_q;
   assign frame_err  = frame_err_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fc_flatten_buffer.sv
// Purpose : checks fc_flatten_buffer framing, row packing, read mirroring and FC handshake.
// Latency : n/a.
// Backpr. : drives in_valid and honours in_ready.
module tb_fc_flatten_buffer;

   localparam int DW    = 16;
   localparam int LN    = 16;
   localparam int NODES = 784;
   localparam int RW    = DW * LN;

   typedef struct {
      int            kind;   // 0 fc_data, 1 fc_start, 2 in_ready, 3 frame_err, 4 frame_done
      logic [RW-1:0] val;
      string         name;
   } exp_t;

   exp_t exp_q[$];
   int   total    = 0;
   int   bad      = 0;
   int   exp_err  = 0;
   int   exp_done = 0;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [6:0]    fc_weight_addr = '0;
   logic [RW-1:0] fc_data;
   logic          fc_start;
   logic          fc_done = 1'b0;
   logic          frame_err;
   logic          frame_done;

   always #5 clk = ~clk;

   fc_flatten_buffer dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .fc_weight_addr (fc_weight_addr),
      .fc_data        (fc_data),
      .fc_start       (fc_start),
      .fc_done        (fc_done),
      .frame_err      (frame_err),
      .frame_done     (frame_done)
   );

   // Row r of a frame whose element k carries base + mult*k.
   function automatic logic [RW-1:0] exp_row(input int base, input int mult, input int r);
      logic [RW-1:0] v;
      for (int l = 0; l < LN; l++) v[l*DW +: DW] = DW'(base + mult * (r * LN + l));
      return v;
   endfunction

   task automatic exp_chk(input int kind, input logic [RW-1:0] val, input string name);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd_chk(input logic [6:0] addr, input logic [RW-1:0] val, input string name);
      fc_weight_addr = addr;
      exp_chk(0, val, name);
      step(1);
   endtask

   task automatic push_elem(input logic [DW-1:0] d, input logic last);
      int w;
      w        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && w < 200) begin
         step(1);
         w++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL in_ready wait: got %b expected 1", in_ready);
      end
      step(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int n, input int base, input int mult, input bit last_ok, input bit gaps);
      logic lst;
      for (int k = 0; k < n; k++) begin
         if (gaps && ($urandom_range(1, 0) == 1)) begin
            in_valid = 1'b0;
            step(1);
         end
         lst = (k == n - 1) ? last_ok : 1'b0;
         if (lst != (k == NODES - 1)) exp_err++;
         push_elem(DW'(base + mult * k), lst);
      end
   endtask

   // Called in a RUN cycle: fc_done, one GAP cycle, then back to FILL.
   task automatic done_seq(input string tag);
      fc_done = 1'b1;
      exp_done++;
      step(1);
      fc_done = 1'b0;
      exp_chk(1, '0, {tag, " GAP fc_start"});
      exp_chk(2, '0, {tag, " GAP in_ready"});
      exp_chk(0, '0, {tag, " GAP fc_data"});
      exp_chk(4, RW'(1), {tag, " frame_done"});
      step(1);
      exp_chk(2, RW'(1), {tag, " FILL in_ready"});
      exp_chk(1, '0, {tag, " FILL fc_start"});
      step(1);
   endtask

   // Scoreboard monitor: pops everything queued this cycle, and accounts for
   // every framing / completion pulse the DUT raises.
   always @(negedge clk) begin
      exp_t          e;
      logic [RW-1:0] act;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            0:       act = fc_data;
            1:       act = RW'(fc_start);
            2:       act = RW'(in_ready);
            3:       act = RW'(frame_err);
            default: act = RW'(frame_done);
         endcase
         total++;
         if (act !== e.val) begin
            bad++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
      if (frame_err !== 1'b0) begin
         total++;
         if (exp_err > 0) exp_err--;
         else begin
            bad++;
            $display("FAIL frame_err pulse: got %b expected 0", frame_err);
         end
      end
      if (frame_done !== 1'b0) begin
         total++;
         if (exp_done > 0) exp_done--;
         else begin
            bad++;
            $display("FAIL frame_done pulse: got %b expected 0", frame_done);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(2);
      exp_chk(2, '0, "reset in_ready");
      exp_chk(1, '0, "reset fc_start");
      exp_chk(0, '0, "reset fc_data");
      exp_chk(3, '0, "reset frame_err");
      exp_chk(4, '0, "reset frame_done");
      step(1);
      reset = 1'b1;
      step(1);
      exp_chk(2, RW'(1), "release in_ready");
      exp_chk(1, '0, "release fc_start");
      exp_chk(0, '0, "fill fc_data");
      step(1);

`ifdef FC_BUF_PINGPONG_EN
      send_frame(NODES, 0, 1, 1'b1, 1'b0);
      exp_chk(1, RW'(1), "PP A fc_start");
      exp_chk(2, RW'(1), "PP A in_ready");
      rd_chk(7'd0, exp_row(0, 1, 0), "PP A addr0");
      send_frame(NODES, 2000, 1, 1'b1, 1'b0);
      exp_chk(1, RW'(1), "PP B fc_start");
      rd_chk(7'd48, exp_row(0, 1, 48), "PP A addr48 after B");
      in_valid = 1'b1;
      in_data  = 16'h1234;
      exp_chk(2, '0, "PP stall in_ready 0");
      step(1);
      exp_chk(2, '0, "PP stall in_ready 1");
      step(1);
      in_valid       = 1'b0;
      fc_weight_addr = 7'd0;
      fc_done        = 1'b1;
      exp_done++;
      step(1);
      fc_done = 1'b0;
      exp_chk(1, '0, "PP GAP fc_start");
      exp_chk(2, RW'(1), "PP GAP in_ready");
      exp_chk(4, RW'(1), "PP frame_done");
      step(1);
      exp_chk(1, RW'(1), "PP restart fc_start");
      rd_chk(7'd0, exp_row(2000, 1, 0), "PP B addr0");
      rd_chk(7'd97, exp_row(2000, 1, 48), "PP B addr97");
      send_frame(NODES, 4000, 1, 1'b1, 1'b0);
      exp_chk(2, '0, "PP C in_ready");
      fc_done = 1'b1;
      exp_done++;
      step(1);
      fc_done = 1'b0;
      step(1);
      exp_chk(1, RW'(1), "PP C fc_start");
      rd_chk(7'd5, exp_row(4000, 1, 5), "PP C addr5");
      fc_done = 1'b1;
      exp_done++;
      step(2);
      fc_done = 1'b0;
      exp_chk(2, RW'(1), "PP idle in_ready");
      exp_chk(1, '0, "PP idle fc_start");
      step(1);
`else
      send_frame(NODES, 0, 1, 1'b1, 1'b0);
      exp_chk(1, RW'(1), "A fc_start");
      exp_chk(2, '0, "A RUN in_ready");
      rd_chk(7'd0,   exp_row(0, 1, 0),  "A addr0");
      rd_chk(7'd48,  exp_row(0, 1, 48), "A addr48");
      rd_chk(7'd49,  exp_row(0, 1, 0),  "A addr49");
      rd_chk(7'd97,  exp_row(0, 1, 48), "A addr97");
      rd_chk(7'd98,  '0,                "A addr98");
      rd_chk(7'd99,  '0,                "A addr99");
      rd_chk(7'd127, '0,                "A addr127");
      done_seq("A");

      fc_done = 1'b1;
      step(1);
      fc_done = 1'b0;
      exp_chk(4, '0, "fc_done in FILL ignored");
      exp_chk(1, '0, "fc_done in FILL fc_start");
      step(1);

      send_frame(101, 9000, 1, 1'b1, 1'b0);
      exp_chk(2, RW'(1), "short frame in_ready");
      exp_chk(1, '0, "short frame fc_start");
      step(1);

      send_frame(NODES, 1000, 1, 1'b1, 1'b0);
      rd_chk(7'd0,  exp_row(1000, 1, 0),  "B addr0");
      rd_chk(7'd48, exp_row(1000, 1, 48), "B addr48");
      done_seq("B");

      send_frame(NODES, 0, 1, 1'b1, 1'b1);
      rd_chk(7'd0,  exp_row(0, 1, 0),  "C gaps addr0");
      rd_chk(7'd30, exp_row(0, 1, 30), "C gaps addr30");
      rd_chk(7'd48, exp_row(0, 1, 48), "C gaps addr48");
      done_seq("C");

      send_frame(NODES, 5, 3, 1'b0, 1'b0);
      exp_chk(1, RW'(1), "D no-last fc_start");
      rd_chk(7'd60, exp_row(5, 3, 11), "D addr60");

      fc_weight_addr = 7'd0;
      reset = 1'b0;
      exp_chk(1, '0, "midrun reset fc_start");
      exp_chk(0, '0, "midrun reset fc_data");
      exp_chk(2, '0, "midrun reset in_ready");
      step(1);
      reset = 1'b1;
      step(1);
      exp_chk(2, RW'(1), "post reset in_ready");
      exp_chk(1, '0, "post reset fc_start");
      step(1);

      send_frame(NODES, 77, 2, 1'b1, 1'b0);
      rd_chk(7'd0,  exp_row(77, 2, 0),  "E addr0");
      rd_chk(7'd48, exp_row(77, 2, 48), "E addr48");
      done_seq("E");
`endif

      step(2);
      total++;
      if (exp_err != 0) begin
         bad++;
         $display("FAIL frame_err count: got %0d missing expected 0", exp_err);
      end
      total++;
      if (exp_done != 0) begin
         bad++;
         $display("FAIL frame_done count: got %0d missing expected 0", exp_done);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
